// File: rtl/glitch_sequencer.sv
// glitch_sequencer: waits for an armed trigger rising edge, counts a programmed
// offset, then fires one or more duration_counter pulses of programmed width
// separated by a programmed gap. Abort returns to IDLE and resets the counter.
module glitch_sequencer #(
    parameter int W  = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          arm,
    input  logic          abort,
    input  logic          trigger,
    input  logic [W-1:0]  cfg_offset,
    input  logic [W-1:0]  cfg_width,
    input  logic [W-1:0]  cfg_gap,
    input  logic [CW-1:0] cfg_count,
    input  logic          dc_active_low,
    output logic          dc_enable,
    output logic [W-1:0]  dc_din,
    output logic          dc_reset,
    output logic          armed,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] glitch_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_FIRE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          trig_q;
    logic          trig_edge;
    logic          al_q;
    logic          seen_low;
    logic          seen_low_nx;
    logic [W-1:0]  cnt;
    logic [W-1:0]  cnt_nx;
    logic [W-1:0]  offset_q;
    logic [W-1:0]  gap_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] idx_nx;
    logic          cfg_load;
    logic          dc_reset_q;

    assign trig_edge = trigger & ~trig_q;

    // Input history: trigger edge detector and a registered view of the pulse
    // generator output. al_q idles high, matching an inactive active-low pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_q <= 1'b0;
            al_q   <= 1'b1;
        end else begin
            trig_q <= trigger;
            al_q   <= dc_active_low;
        end
    end

    // Sequencer state, countdown, pulse bookkeeping and the abort reset strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            seen_low   <= 1'b0;
            glitch_idx <= '0;
            dc_reset_q <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            seen_low   <= seen_low_nx;
            glitch_idx <= idx_nx;
            dc_reset_q <= abort;
        end
    end

    // Configuration snapshot taken on arm; a count of 0 is stored as 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            offset_q <= '0;
            dc_din   <= '0;
            gap_q    <= '0;
            count_q  <= '0;
        end else if (cfg_load) begin
            offset_q <= cfg_offset;
            dc_din   <= cfg_width;
            gap_q    <= cfg_gap;
            count_q  <= (cfg_count == '0) ? CW'(1) : cfg_count;
        end
    end

    // Next-state logic; abort overrides every other event, including arm.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        seen_low_nx = seen_low;
        idx_nx      = glitch_idx;
        cfg_load    = 1'b0;
        if (abort) begin
            state_nx    = S_IDLE;
            cnt_nx      = '0;
            seen_low_nx = 1'b0;
            idx_nx      = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        cfg_load = 1'b1;
                        idx_nx   = '0;
                        state_nx = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trig_edge) begin
                        cnt_nx   = offset_q;
                        state_nx = S_DELAY;
                    end
                end
                S_DELAY, S_GAP: begin
                    if (cnt == '0) begin
                        state_nx = S_FIRE;
                    end else begin
                        cnt_nx = cnt - W'(1);
                    end
                end
                S_FIRE: begin
                    idx_nx      = glitch_idx + CW'(1);
                    seen_low_nx = 1'b0;
                    state_nx    = S_WAIT;
                end
                S_WAIT: begin
                    if (!al_q) begin
                        seen_low_nx = 1'b1;
                    end else if (seen_low) begin
                        if (glitch_idx == count_q) begin
                            state_nx = S_DONE;
                        end else begin
                            cnt_nx   = gap_q;
                            state_nx = S_GAP;
                        end
                    end
                end
                S_DONE: begin
                    state_nx = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Status and strobe outputs decoded from state; abort suppresses strobes.
    always_comb begin
        dc_enable = (state == S_FIRE) && !abort;
        done      = (state == S_DONE) && !abort;
        armed     = (state == S_ARMED);
        busy      = (state != S_IDLE);
        dc_reset  = dc_reset_q;
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: reference schedule model feeding a scoreboard,
// a behavioural duration_counter, and a monitor that checks every strobe.
module tb_glitch_sequencer;

    localparam int W  = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          arm;
    logic          abort;
    logic          trigger;
    logic [W-1:0]  cfg_offset;
    logic [W-1:0]  cfg_width;
    logic [W-1:0]  cfg_gap;
    logic [CW-1:0] cfg_count;
    logic          dc_active_low;
    logic          dc_enable;
    logic [W-1:0]  dc_din;
    logic          dc_reset;
    logic          armed;
    logic          busy;
    logic          done;
    logic [CW-1:0] glitch_idx;

    glitch_sequencer #(.W(W), .CW(CW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .arm           (arm),
        .abort         (abort),
        .trigger       (trigger),
        .cfg_offset    (cfg_offset),
        .cfg_width     (cfg_width),
        .cfg_gap       (cfg_gap),
        .cfg_count     (cfg_count),
        .dc_active_low (dc_active_low),
        .dc_enable     (dc_enable),
        .dc_din        (dc_din),
        .dc_reset      (dc_reset),
        .armed         (armed),
        .busy          (busy),
        .done          (done),
        .glitch_idx    (glitch_idx)
    );

    always #5 clk = ~clk;

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural duration_counter: after an enable, output low for din+1 cycles.
    longint dc_rem = 0;
    assign dc_active_low = (dc_rem == 0);
    always @(posedge clk) begin
        if (dc_reset)       dc_rem <= 0;
        else if (dc_enable) dc_rem <= longint'(dc_din) + 1;
        else if (dc_rem > 0) dc_rem <= dc_rem - 1;
    end

    // Scoreboard entries: kind 0 = dc_reset, 1 = dc_enable, 2 = done.
    typedef struct {
        int          kind;
        longint      cyc;
        int          idx;
        logic [31:0] din;
    } ev_t;

    ev_t sb[$];

    function automatic void sb_put(ev_t e);
        int pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > e.cyc || (sb[i].cyc == e.cyc && sb[i].kind > e.kind)) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endfunction

    // Reference model: 0 = idle, 1 = armed, 2 = sequence scheduled until m_end.
    int          m_mode = 0;
    logic        m_trig_prev = 1'b0;
    logic        m_edge;
    longint      m_off, m_w, m_g, m_end, m_e0, m_per;
    logic [31:0] m_din;
    int          m_n;
    int          m_final_idx = 0;
    ev_t         m_ev;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb.delete();
            m_mode      = 0;
            m_trig_prev = 1'b0;
            m_final_idx = 0;
        end else begin
            m_edge = trigger && !m_trig_prev;
            if (abort) begin
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].cyc >= cyc) sb.delete(i);
                m_ev.kind = 0; m_ev.cyc = cyc + 1; m_ev.idx = 0; m_ev.din = '0;
                sb_put(m_ev);
                m_mode      = 0;
                m_final_idx = 0;
            end else if (m_mode == 0 && arm) begin
                m_off       = cfg_offset;
                m_w         = cfg_width;
                m_g         = cfg_gap;
                m_din       = cfg_width;
                m_n         = (cfg_count == 0) ? 1 : int'(cfg_count);
                m_final_idx = 0;
                m_mode      = 1;
            end else if (m_mode == 1 && m_edge) begin
                m_e0  = cyc + 2 + m_off;
                m_per = m_w + m_g + 5;
                for (int k = 0; k < m_n; k++) begin
                    m_ev.kind = 1; m_ev.cyc = m_e0 + k * m_per; m_ev.idx = k; m_ev.din = m_din;
                    sb_put(m_ev);
                end
                m_end = m_e0 + (m_n - 1) * m_per + m_w + 4;
                m_ev.kind = 2; m_ev.cyc = m_end; m_ev.idx = m_n; m_ev.din = '0;
                sb_put(m_ev);
                m_mode = 2;
            end else if (m_mode == 2 && cyc == m_end) begin
                m_mode      = 0;
                m_final_idx = m_n;
            end
            m_trig_prev = trigger;
        end
    end

    function automatic string kname(input int k);
        return (k == 0) ? "dc_reset" : (k == 1) ? "dc_enable" : "done";
    endfunction

    task automatic check_ev(input int k);
        ev_t e;
        n_vec++;
        if (sb.size() == 0 || sb[0].cyc != cyc || sb[0].kind != k) begin
            n_err++;
            if (sb.size() == 0)
                $display("FAIL unexpected_%s: seen at cycle %0d, required none pending", kname(k), cyc);
            else
                $display("FAIL unexpected_%s: seen at cycle %0d, required next %s at cycle %0d",
                         kname(k), cyc, kname(sb[0].kind), sb[0].cyc);
        end else begin
            e = sb.pop_front();
            if (glitch_idx !== CW'(e.idx) || (k == 1 && dc_din !== e.din)) begin
                n_err++;
                $display("FAIL %s_fields: cycle %0d idx %0d din 0x%0h, required idx %0d din 0x%0h",
                         kname(k), cyc, glitch_idx, dc_din, e.idx, e.din);
            end
        end
    endtask

    // Monitor: pops and compares whenever the DUT presents a strobe.
    always @(negedge clk) begin
        #1;
        if (reset_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL missed_%s: required at cycle %0d, not seen by cycle %0d",
                         kname(sb[0].kind), sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (dc_reset)  check_ev(0);
            if (dc_enable) check_ev(1);
            if (done)      check_ev(2);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input logic [31:0] off, input logic [31:0] w, input logic [31:0] g,
                           input logic [7:0] cn, input int abort_at, input bit hold_trig,
                           input bit noise);
        int n;
        for (int i = 0; i < 4; i++) begin
            trigger = 1'($urandom_range(0, 1));
            step();
        end
        trigger = hold_trig;
        step();
        cfg_offset = off; cfg_width = w; cfg_gap = g; cfg_count = cn;
        arm = 1'b1;
        step();
        arm        = 1'b0;
        cfg_offset = $urandom; cfg_width = $urandom; cfg_gap = $urandom;
        cfg_count  = 8'($urandom);
        if (hold_trig) begin
            repeat (3) step();
            trigger = 1'b0;
            step();
        end
        repeat ($urandom_range(0, 2)) step();
        trigger = 1'b1;
        step();
        n = 0;
        while ((m_mode != 0 || sb.size() != 0) && n < 4000) begin
            abort = (n == abort_at);
            if (noise) begin
                trigger = 1'($urandom_range(0, 1));
                arm     = (m_mode == 2) && ($urandom_range(0, 5) == 0);
            end
            step();
            n++;
        end
        abort = 1'b0; arm = 1'b0; trigger = 1'b0;
        chk("seq_finished_in_bound", (n < 4000), 1);
        step();
        step();
        chk("idle_busy", busy, 0);
        chk("idle_armed", armed, 0);
        chk("final_glitch_idx", glitch_idx, m_final_idx);
    endtask

    initial begin
        reset_n = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
        cfg_offset = '0; cfg_width = '0; cfg_gap = '0; cfg_count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_armed", armed, 0);
        chk("rst_done", done, 0);
        chk("rst_dc_enable", dc_enable, 0);
        chk("rst_dc_reset", dc_reset, 0);
        chk("rst_dc_din", dc_din, 0);
        chk("rst_glitch_idx", glitch_idx, 0);
        reset_n = 1'b1;
        step();

        run_seq(32'd0, 32'd3, 32'd0, 8'd1, -1, 1'b0, 1'b0);
        run_seq(32'd5, 32'd2, 32'd4, 8'd3, -1, 1'b0, 1'b0);
        run_seq(32'd5, 32'd2, 32'd4, 8'd0, -1, 1'b0, 1'b0);
        run_seq(32'd1, 32'd5, 32'd2, 8'd4, 16, 1'b0, 1'b0);
        run_seq(32'd2, 32'd1, 32'd3, 8'd2, -1, 1'b1, 1'b1);
        run_seq(32'hFFFF_FFFF, 32'd0, 32'd0, 8'd1, 150, 1'b0, 1'b0);

        // Asynchronous reset in the middle of DELAY.
        cfg_offset = 32'd30; cfg_width = 32'd1; cfg_gap = 32'd1; cfg_count = 8'd1;
        trigger = 1'b0;
        step();
        arm = 1'b1;
        step();
        arm     = 1'b0;
        trigger = 1'b1;
        step();
        repeat (5) step();
        chk("pre_async_busy", busy, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_armed", armed, 0);
        chk("async_dc_enable", dc_enable, 0);
        chk("async_done", done, 0);
        chk("async_dc_reset", dc_reset, 0);
        chk("async_dc_din", dc_din, 0);
        chk("async_glitch_idx", glitch_idx, 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            trigger = (i % 4) >= 2;
            step();
        end
        trigger = 1'b0;
        chk("post_reset_busy", busy, 0);
        chk("post_reset_armed", armed, 0);

        for (int t = 0; t < 25; t++) begin
            run_seq(32'($urandom_range(0, 6)), 32'($urandom_range(0, 4)),
                    32'($urandom_range(0, 5)), 8'($urandom_range(0, 4)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/glitch_sequencer.md
# glitch_sequencer

Schedules glitch pulses for the fault-injection path by driving the `duration_counter` pulse generator. It waits for an armed trigger edge, counts a programmable offset, then fires one or more glitches of programmed width separated by a programmed gap. It sits between the host configuration registers and the `duration_counter` instance. It owns that instance's `enable`, `din` and `reset` inputs and monitors its `active_low` output.

## Interface
- `W`, default 32: width of offset, width and gap counters.
- `CW`, default 8: width of the glitch-count field.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `arm`  in  1  single-cycle request; in IDLE it latches the config and enters ARMED.
- `abort`  in  1  forces return to IDLE from any state.
- `trigger`  in  1  synchronous target trigger; only rising edges are used.
- `cfg_offset`  in  W  cycles from trigger edge to first glitch.
- `cfg_width`  in  W  value passed to `duration_counter.din`.
- `cfg_gap`  in  W  cycles between end of one glitch and start of the next.
- `cfg_count`  in  CW  number of glitches; 0 is treated as 1.
- `dc_active_low`  in  1  `active_low` from `duration_counter`.
- `dc_enable`  out  1  one-cycle fire strobe to `duration_counter.enable`.
- `dc_din`  out  W  latched width, held stable from arm to IDLE.
- `dc_reset`  out  1  one-cycle active-high reset to `duration_counter` on abort.
- `armed`  out  1  high in ARMED.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at sequence completion.
- `glitch_idx`  out  CW  number of glitches already fired in this sequence.

## Operation
- Reset values: all outputs 0, state IDLE, `trig_q` = 0, counters 0.
- `trig_q` is a one-cycle registered copy of `trigger`. An edge is `trigger & ~trig_q`. `trig_q` updates in every state.
- IDLE: on `arm`, latch offset/width/gap/count and clear `glitch_idx`, then go to ARMED.
- ARMED: on an edge, load `cnt` = offset and go to DELAY.
- DELAY: if `cnt` == 0, go to FIRE; otherwise decrement `cnt`.
- FIRE: hold `dc_enable` = 1 for this cycle only, increment `glitch_idx`, clear `seen_low`, go to WAIT.
- WAIT:
  - Set `seen_low` when `dc_active_low` == 0.
  - When `seen_low` is set and `dc_active_low` == 1:
    - If `glitch_idx` == effective count, go to DONE.
    - Otherwise load `cnt` = gap and go to GAP.
- GAP: same countdown as DELAY, exits to FIRE.
- DONE: `done` = 1 for this cycle only, then go to IDLE.
- `abort` takes priority over every other event, including `arm` in the same cycle. It sends the state to IDLE, clears `dc_enable`, and drives `dc_reset` = 1 for one cycle. The abort also clears `glitch_idx`.
- `arm` outside IDLE is ignored. Trigger edges outside ARMED are ignored (no retrigger, no queueing).
- Config inputs are only sampled at arm; changing them mid-sequence has no effect.
- Counters are unsigned and decrement only when nonzero, so there is no wrap-around. An offset or gap of 2^W−1 is legal.
- Asserting `reset_n` low mid-sequence immediately returns everything to reset values. The downstream counter is reset separately by its own reset.

## Timing
- Let T be the cycle in which the trigger edge is detected in ARMED.
  - DELAY spans T+1 .. T+1+offset.
  - `dc_enable` is high in cycle T+2+offset.
- With a standard `duration_counter`:
  - `active_low` goes low at T+3+offset and stays low for width+1 cycles.
  - Its return high is seen in WAIT, and the next state is taken one cycle later.
- Consecutive enables are separated by (width+1) + gap + 4 cycles. This follows from the state path: FIRE, one WAIT cycle before low, width+1 low cycles, one exit cycle, GAP of gap+1 cycles.
- `done` is asserted 2 cycles after `dc_active_low` returns high on the final glitch.
- `dc_din` is valid at least from arm through DONE.

## Test plan
- Single glitch, offset 0, width 3, count 1:
  - `dc_enable` high at T+2.
  - `dc_active_low` low for 4 cycles.
  - `done` pulses once, `glitch_idx` = 1, `busy` returns to 0.
- Burst, offset 5, width 2, gap 4, count 3:
  - Exactly 3 `dc_enable` strobes.
  - First strobe at T+7; strobes are 11 cycles apart.
  - `glitch_idx` ends at 3, single `done`.
- `cfg_count` = 0 behaves identically to count 1.
- Abort during the second pulse of a count-4 burst:
  - `dc_reset` pulses.
  - State is IDLE the next cycle and no further `dc_enable` occurs.
  - `done` never asserts.
- Robustness cases:
  - Triggers before arm, and extra trigger edges during DELAY/GAP, are ignored.
  - `trigger` held high while arming produces no fire until a fresh rising edge.
  - `arm` while busy has no effect.
- Async reset mid-DELAY: drive `reset_n` low off the clock edge.
  - All outputs are 0 immediately.
  - After release, the block stays IDLE until a new `arm`.
